// File: rtl/vid_stream_testgen.sv
// AXI4-Stream video test pattern master: emits raster frames (tuser on first pixel,
// tlast on each line end) with selectable patterns, honouring tready backpressure.
`timescale 1ns/1ps

module vid_stream_testgen (
    input  logic        m_axis_vid_aclk,
    input  logic        aresetn,
    output logic [31:0] m_axis_vid_tdata,
    output logic        m_axis_vid_tvalid,
    input  logic        m_axis_vid_tready,
    output logic        m_axis_vid_tlast,
    output logic [0:0]  m_axis_vid_tuser,
    input  logic        cfg_enable,
    input  logic [11:0] cfg_width,
    input  logic [11:0] cfg_height,
    input  logic [1:0]  cfg_pattern,
    input  logic [23:0] cfg_color,
    input  logic [7:0]  cfg_line_gap,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        LINE_GAP
    } state_t;

    state_t      state;
    logic [11:0] width_q;
    logic [11:0] height_q;
    logic [1:0]  pattern_q;
    logic [23:0] color_q;
    logic [7:0]  gap_q;
    logic [7:0]  gap_cnt;
    logic [11:0] x;
    logic [11:0] y;

    logic        handshake;
    logic        last_x;
    logic        last_y;
    logic [11:0] x_next;
    logic [11:0] y_next;

    function automatic logic [31:0] pixel(
        input logic [11:0] px,
        input logic [11:0] py,
        input logic [1:0]  pat,
        input logic [23:0] col
    );
        case (pat)
            2'd0:    pixel = {8'h00, col};
            2'd1:    pixel = {8'h00, px[7:0], px[7:0], px[7:0]};
            2'd2:    pixel = (px[4] ^ py[4]) ? {8'h00, col} : 32'h0;
            default: pixel = {4'h0, py, 4'h0, px};
        endcase
    endfunction

    assign handshake = m_axis_vid_tvalid & m_axis_vid_tready;
    assign last_x    = (x == width_q - 12'd1);
    assign last_y    = (y == height_q - 12'd1);
    assign x_next    = x + 12'd1;
    assign y_next    = y + 12'd1;

    // The next beat is always computed one step ahead so tdata/tlast/tuser are
    // registered and only move on a handshake, never during a stall.
    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            state             <= IDLE;
            width_q           <= 12'd0;
            height_q          <= 12'd0;
            pattern_q         <= 2'd0;
            color_q           <= 24'd0;
            gap_q             <= 8'd0;
            gap_cnt           <= 8'd0;
            x                 <= 12'd0;
            y                 <= 12'd0;
            m_axis_vid_tdata  <= 32'd0;
            m_axis_vid_tvalid <= 1'b0;
            m_axis_vid_tlast  <= 1'b0;
            m_axis_vid_tuser  <= 1'b0;
            frame_done        <= 1'b0;
            frame_count       <= 16'd0;
            busy              <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_enable && (cfg_width != 12'd0) && (cfg_height != 12'd0)) begin
                        width_q           <= cfg_width;
                        height_q          <= cfg_height;
                        pattern_q         <= cfg_pattern;
                        color_q           <= cfg_color;
                        gap_q             <= cfg_line_gap;
                        x                 <= 12'd0;
                        y                 <= 12'd0;
                        m_axis_vid_tdata  <= pixel(12'd0, 12'd0, cfg_pattern, cfg_color);
                        m_axis_vid_tlast  <= (cfg_width == 12'd1);
                        m_axis_vid_tuser  <= 1'b1;
                        m_axis_vid_tvalid <= 1'b1;
                        busy              <= 1'b1;
                        state             <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (handshake) begin
                        m_axis_vid_tuser <= 1'b0;
                        if (!last_x) begin
                            x                <= x_next;
                            m_axis_vid_tdata <= pixel(x_next, y, pattern_q, color_q);
                            m_axis_vid_tlast <= (x_next == width_q - 12'd1);
                        end else if (!last_y) begin
                            x                <= 12'd0;
                            y                <= y_next;
                            m_axis_vid_tdata <= pixel(12'd0, y_next, pattern_q, color_q);
                            m_axis_vid_tlast <= (width_q == 12'd1);
                            if (gap_q != 8'd0) begin
                                m_axis_vid_tvalid <= 1'b0;
                                gap_cnt           <= gap_q;
                                state             <= LINE_GAP;
                            end
                        end else begin
                            m_axis_vid_tvalid <= 1'b0;
                            m_axis_vid_tlast  <= 1'b0;
                            frame_done        <= 1'b1;
                            frame_count       <= frame_count + 16'd1;
                            busy              <= 1'b0;
                            state             <= IDLE;
                        end
                    end
                end

                LINE_GAP: begin
                    // The entry cycle counts as the first gap cycle, hence the stop at 1.
                    if (gap_cnt == 8'd1) begin
                        m_axis_vid_tvalid <= 1'b1;
                        state             <= ACTIVE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vid_stream_testgen.sv
// Self-checking bench for vid_stream_testgen: scoreboarded beats, stall stability,
// line/frame gaps, enable drop, mid-frame reset and degenerate sizes.
`timescale 1ns/1ps

module tb_vid_stream_testgen;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [0:0]  tuser;
    logic        cfg_enable;
    logic [11:0] cfg_width;
    logic [11:0] cfg_height;
    logic [1:0]  cfg_pattern;
    logic [23:0] cfg_color;
    logic [7:0]  cfg_line_gap;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] exp_q[$];
    int          gap_q[$];
    bit          rand_ready = 1'b0;
    bit          stall_prev = 1'b0;
    logic [33:0] stall_vals = '0;
    int          beats = 0;
    int          drop_at_beat = 0;
    logic [11:0] new_width = 12'd0;
    int          done_pulses = 0;
    bit          in_gap = 1'b0;
    int          gap_len = 0;
    int          exp_frames = 0;

    always #5 clk = ~clk;

    vid_stream_testgen dut (
        .m_axis_vid_aclk   (clk),
        .aresetn           (aresetn),
        .m_axis_vid_tdata  (tdata),
        .m_axis_vid_tvalid (tvalid),
        .m_axis_vid_tready (tready),
        .m_axis_vid_tlast  (tlast),
        .m_axis_vid_tuser  (tuser),
        .cfg_enable        (cfg_enable),
        .cfg_width         (cfg_width),
        .cfg_height        (cfg_height),
        .cfg_pattern       (cfg_pattern),
        .cfg_color         (cfg_color),
        .cfg_line_gap      (cfg_line_gap),
        .frame_done        (frame_done),
        .frame_count       (frame_count),
        .busy              (busy)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pixModel(input int px, input int py,
                                             input logic [1:0] pat, input logic [23:0] col);
        logic [7:0] x8;
        x8 = px[7:0];
        case (pat)
            2'd0:    return {8'h00, col};
            2'd1:    return {8'h00, x8, x8, x8};
            2'd2:    return (((px / 16) % 2) != ((py / 16) % 2)) ? {8'h00, col} : 32'h0;
            default: return 32'(py * 65536 + px);
        endcase
    endfunction

    task automatic pushFrame(input int w, input int h, input logic [1:0] pat, input logic [23:0] col);
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                exp_q.push_back({(xx == 0 && yy == 0), (xx == w - 1), pixModel(xx, yy, pat, col)});
            end
        end
    endtask

    task automatic applyStimulus(input logic [11:0] w, input logic [11:0] h, input logic [1:0] pat,
                                 input logic [23:0] col, input logic [7:0] gap);
        cfg_width    = w;
        cfg_height   = h;
        cfg_pattern  = pat;
        cfg_color    = col;
        cfg_line_gap = gap;
        cfg_enable   = 1'b1;
        new_width    = w;
        drop_at_beat = 1;
        beats        = 0;
        done_pulses  = 0;
        in_gap       = 1'b0;
        gap_q.delete();
    endtask

    // One clock: drive tready at the falling edge, then sample what the DUT will
    // present at the next rising edge and score any handshake.
    task automatic checkOutput();
        logic [33:0] exp;
        @(negedge clk);
        tready = rand_ready ? ($urandom_range(0, 1) == 32'd1) : 1'b1;
        #1;
        if (frame_done) done_pulses++;
        if (stall_prev)
            checkVal("stall_hold", 64'({tvalid, tuser, tlast, tdata}), 64'({1'b1, stall_vals}));
        if (tvalid) begin
            if (in_gap) begin
                gap_q.push_back(gap_len);
                in_gap = 1'b0;
            end
        end else if (in_gap) begin
            gap_len++;
        end
        if (tvalid && tready) begin
            beats++;
            checkVal("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                checkVal("beat", 64'({tuser, tlast, tdata}), 64'(exp));
            end
            if (tlast) begin
                in_gap  = 1'b1;
                gap_len = 0;
            end
            if (beats == drop_at_beat) begin
                cfg_enable = 1'b0;
                cfg_width  = new_width;
            end
        end
        stall_prev = tvalid && !tready;
        stall_vals = {tuser, tlast, tdata};
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            checkOutput();
            n++;
        end
        checkVal("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) checkOutput();
    endtask

    initial begin
        int n;
        aresetn      = 1'b0;
        tready       = 1'b1;
        cfg_enable   = 1'b0;
        cfg_width    = 12'd0;
        cfg_height   = 12'd0;
        cfg_pattern  = 2'd0;
        cfg_color    = 24'd0;
        cfg_line_gap = 8'd0;

        $display("[TB] reset state");
        idle(3);
        checkVal("rst_tvalid", 64'(tvalid), 64'd0);
        checkVal("rst_tdata", 64'(tdata), 64'd0);
        checkVal("rst_tlast", 64'(tlast), 64'd0);
        checkVal("rst_tuser", 64'(tuser), 64'd0);
        checkVal("rst_frame_done", 64'(frame_done), 64'd0);
        checkVal("rst_frame_count", 64'(frame_count), 64'd0);
        checkVal("rst_busy", 64'(busy), 64'd0);
        aresetn = 1'b1;
        idle(2);

        $display("[TB] basic 4x2 coordinate frame");
        applyStimulus(12'd4, 12'd2, 2'd3, 24'h0, 8'd0);
        pushFrame(4, 2, 2'd3, 24'h0);
        checkOutput();
        checkVal("busy_in_frame", 64'(busy), 64'd1);
        drain(50);
        idle(4);
        exp_frames++;
        checkVal("basic_beats", 64'(beats), 64'd8);
        checkVal("basic_done_pulses", 64'(done_pulses), 64'd1);
        checkVal("basic_frame_count", 64'(frame_count), 64'(exp_frames));
        checkVal("basic_busy_after", 64'(busy), 64'd0);

        $display("[TB] backpressure");
        rand_ready = 1'b1;
        applyStimulus(12'd4, 12'd2, 2'd3, 24'h0, 8'd0);
        pushFrame(4, 2, 2'd3, 24'h0);
        drain(200);
        rand_ready = 1'b0;
        idle(4);
        exp_frames++;
        checkVal("bp_done_pulses", 64'(done_pulses), 64'd1);
        checkVal("bp_frame_count", 64'(frame_count), 64'(exp_frames));

        $display("[TB] line gap 3x3 gap 2, two back-to-back frames");
        applyStimulus(12'd3, 12'd3, 2'd2, 24'hABCDEF, 8'd2);
        drop_at_beat = 10;
        pushFrame(3, 3, 2'd2, 24'hABCDEF);
        pushFrame(3, 3, 2'd2, 24'hABCDEF);
        drain(200);
        idle(4);
        exp_frames += 2;
        checkVal("gap_count", 64'(gap_q.size()), 64'd5);
        if (gap_q.size() == 5) begin
            checkVal("gap_line1", 64'(gap_q[0]), 64'd2);
            checkVal("gap_line2", 64'(gap_q[1]), 64'd2);
            checkVal("gap_frame", 64'(gap_q[2] >= 1 && gap_q[2] <= 2), 64'd1);
            checkVal("gap_line4", 64'(gap_q[3]), 64'd2);
            checkVal("gap_line5", 64'(gap_q[4]), 64'd2);
        end
        checkVal("gap_frame_count", 64'(frame_count), 64'(exp_frames));

        $display("[TB] enable drop and width change mid-frame");
        applyStimulus(12'd8, 12'd4, 2'd1, 24'h0000AA, 8'd0);
        new_width    = 12'd2;
        drop_at_beat = 5;
        pushFrame(8, 4, 2'd1, 24'h0000AA);
        drain(200);
        idle(10);
        exp_frames++;
        checkVal("drop_beats", 64'(beats), 64'd32);
        checkVal("drop_tvalid_idle", 64'(tvalid), 64'd0);
        checkVal("drop_frame_count", 64'(frame_count), 64'(exp_frames));
        cfg_enable   = 1'b1;
        beats        = 0;
        drop_at_beat = 1;
        done_pulses  = 0;
        pushFrame(2, 4, 2'd1, 24'h0000AA);
        drain(100);
        idle(4);
        exp_frames++;
        checkVal("narrow_beats", 64'(beats), 64'd8);
        checkVal("narrow_frame_count", 64'(frame_count), 64'(exp_frames));

        $display("[TB] reset mid-frame");
        applyStimulus(12'd16, 12'd16, 2'd3, 24'h0, 8'd0);
        drop_at_beat = 0;
        pushFrame(16, 16, 2'd3, 24'h0);
        n = 0;
        while (beats < 10 && n < 100) begin
            checkOutput();
            n++;
        end
        checkVal("reach_beat10", 64'(beats), 64'd10);
        aresetn = 1'b0;
        checkOutput();
        checkVal("abort_tvalid", 64'(tvalid), 64'd0);
        checkVal("abort_frame_count", 64'(frame_count), 64'd0);
        checkVal("abort_busy", 64'(busy), 64'd0);
        checkVal("abort_no_done", 64'(done_pulses), 64'd0);
        exp_q.delete();
        exp_frames   = 0;
        aresetn      = 1'b1;
        beats        = 0;
        drop_at_beat = 1;
        in_gap       = 1'b0;
        pushFrame(16, 16, 2'd3, 24'h0);
        drain(600);
        idle(4);
        exp_frames++;
        checkVal("post_reset_done", 64'(done_pulses), 64'd1);
        checkVal("post_reset_frame_count", 64'(frame_count), 64'(exp_frames));

        $display("[TB] degenerate sizes");
        applyStimulus(12'd0, 12'd5, 2'd0, 24'h123456, 8'd0);
        idle(10);
        checkVal("zero_w_tvalid", 64'(tvalid), 64'd0);
        checkVal("zero_w_busy", 64'(busy), 64'd0);
        checkVal("zero_w_beats", 64'(beats), 64'd0);
        checkVal("zero_w_frame_count", 64'(frame_count), 64'(exp_frames));
        applyStimulus(12'd1, 12'd1, 2'd0, 24'h123456, 8'd0);
        pushFrame(1, 1, 2'd0, 24'h123456);
        drain(20);
        idle(4);
        exp_frames++;
        checkVal("one_px_beats", 64'(beats), 64'd1);
        checkVal("one_px_done", 64'(done_pulses), 64'd1);
        checkVal("one_px_frame_count", 64'(frame_count), 64'(exp_frames));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
